// File: rtl/extend.sv
// extend: registered immediate extender forming a 32-bit ExtImm from the low 24 instruction bits
module extend (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] Instr,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] ExtImm
);
  logic [31:0] nxt;
  always_comb
    nxt = ImmSrc == 2'b00 ? {24'b0, Instr[7:0]} :
          ImmSrc == 2'b01 ? {20'b0, Instr[11:0]} :
          ImmSrc == 2'b10 ? {{6{Instr[23]}}, Instr, 2'b00} : 32'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ExtImm <= 32'h0;
    else ExtImm <= nxt;
endmodule

// File: tb/tb_extend.sv
// tb_extend: directed and randomized checks of extend against an arithmetic reference model
module tb_extend;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] instr = 24'h5A5A5A;
  logic [1:0]  imm_src = 2'b10;
  logic [31:0] ext_imm;
  int checks = 0;
  int failures = 0;

  extend dut (.clk(clk), .rst_n(rst_n), .Instr(instr), .ImmSrc(imm_src), .ExtImm(ext_imm));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [23:0] i, logic [1:0] s);
    int sv;
    if (s == 2'd0) return 32'(i % 256);
    if (s == 2'd1) return 32'(i % 4096);
    if (s == 2'd2) begin
      sv = i >= 24'h800000 ? int'(i) - 16777216 : int'(i);
      return 32'(sv * 4);
    end
    return 32'h0;
  endfunction

  task automatic check(string tag, logic [31:0] exp);
    checks++;
    assert (ext_imm === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, ext_imm, exp);
    end
  endtask

  task automatic step(string tag, logic [23:0] i, logic [1:0] s, logic [31:0] exp);
    @(negedge clk);
    instr = i;
    imm_src = s;
    @(posedge clk);
    #1 check(tag, exp);
  endtask

  initial begin
    logic [23:0] ri;
    logic [1:0]  rs;
    #2 check("reset_immediate", 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check("reset_hold", 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    step("dp8", 24'hABCD12, 2'b00, 32'h0000_0012);
    step("ls12", 24'hABCD12, 2'b01, 32'h0000_0D12);
    step("br_pos", 24'h000010, 2'b10, 32'h0000_0040);
    step("br_neg", 24'h800001, 2'b10, 32'hFE00_0004);
    step("br_m1", 24'hFFFFFF, 2'b10, 32'hFFFF_FFFC);
    step("reserved", 24'hFFFFFF, 2'b11, 32'h0000_0000);
    step("br_max", 24'h7FFFFF, 2'b10, 32'h01FF_FFFC);
    step("br_min", 24'h800000, 2'b10, 32'hFE00_0000);
    step("dp8_ignore_hi", 24'hFFFF12, 2'b00, 32'h0000_0012);
    step("ls12_ignore_hi", 24'hFFF345, 2'b01, 32'h0000_0345);
    step("dp8_zero_hi", 24'h000012, 2'b00, 32'h0000_0012);
    @(negedge clk);
    instr = 24'h000123;
    imm_src = 2'b01;
    #2 check("latency_hold", 32'h0000_0012);
    @(posedge clk);
    #1 check("latency_update", 32'h0000_0123);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'h0);
    @(posedge clk);
    #1 check("async_reset_hold", 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step("post_reset", 24'h000123, 2'b01, 32'h0000_0123);
    for (int n = 0; n < 1000; n++) begin
      ri = 24'($urandom);
      rs = 2'($urandom);
      step("random", ri, rs, model(ri, rs));
      if (n == 500) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("random_async_reset", 32'h0);
        @(posedge clk);
        #1 check("random_reset_hold", 32'h0);
        @(negedge clk) rst_n = 1'b1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
